// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter that shares a single fixed-latency ROM read port among NUM_REQ requesters.
// One access is in flight at a time. The next grant can be issued in the cycle that the response is presented.
//
// state  | meaning
// S_IDLE | no access in flight; a grant is issued here if any requester is valid
// S_WAIT | ROM address held stable; the latency counter counts down to the capture edge
module rom_access_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                      clock0,
  input  logic                      global_resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ROM_LATENCY + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  logic                grant_any;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    cand_idx;
  int                  cand;

  // gnt_idx_q serves both as the round-robin pointer and as the index of the in-flight access.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = gnt_idx_q;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(gnt_idx_q) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!grant_any && req_valid[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_ff @(posedge clock0) begin
    if (!global_resetn) begin
      state_q     <= S_IDLE;
      gnt_idx_q   <= IDX_W'(NUM_REQ - 1);
      cnt_q       <= '0;
      addr_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          state_d   = S_WAIT;
          gnt_idx_d = grant_idx;
          cnt_d     = CNT_W'(ROM_LATENCY);
          addr_d    = req_addr[grant_idx*ADDR_W +: ADDR_W];
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // The terminal count is reached on this edge, so rom_data has settled for ROM_LATENCY cycles.
        if (cnt_q == CNT_W'(1)) begin
          state_d                = S_IDLE;
          rsp_data_d             = rom_data;
          rsp_valid_d[gnt_idx_q] = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (global_resetn && (state_q == S_IDLE) && grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
    busy = (state_q == S_WAIT);
  end

  assign rom_address = addr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed and random checks of rom_access_arbiter at ROM latencies 1, 2 and 3.
// The three instances share their request inputs; each test examines only the instance it targets.
module tb_rom_access_arbiter;

  localparam int AW = 7;

  logic        clock0 = 1'b0;
  logic        global_resetn;
  logic [3:0]  req_valid;
  logic [27:0] req_addr;

  logic [3:0]  ready_a, ready_b, ready_c;
  logic [3:0]  rsp_valid_a, rsp_valid_b, rsp_valid_c;
  logic [7:0]  rsp_data_a, rsp_data_b, rsp_data_c;
  logic [6:0]  rom_addr_a, rom_addr_b, rom_addr_c;
  logic [7:0]  rom_data_a, rom_data_b, rom_data_c;
  logic [7:0]  rom_b1, rom_c1, rom_c2;
  logic        busy_a, busy_b, busy_c;

  int n_chk = 0;
  int n_bad = 0;
  int oh_bad = 0;
  logic mon_en = 1'b0;

  always #5 clock0 = ~clock0;

  // Reference ROM contents; the mapping is injective, so every address returns a distinct word.
  function automatic logic [7:0] rom_fn(input logic [6:0] a);
    return {a, 1'b1} ^ 8'hA5;
  endfunction

  // ROM models whose data becomes valid ROM_LATENCY cycles after the address is registered.
  always_comb rom_data_a = rom_fn(rom_addr_a);
  always_ff @(posedge clock0) begin
    rom_b1 <= rom_fn(rom_addr_b);
    rom_c1 <= rom_fn(rom_addr_c);
    rom_c2 <= rom_c1;
  end
  assign rom_data_b = rom_b1;
  assign rom_data_c = rom_c2;

  rom_access_arbiter #(.NUM_REQ(4), .ADDR_W(7), .DATA_W(8), .ROM_LATENCY(1)) u_a (
    .clock0(clock0), .global_resetn(global_resetn), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(ready_a), .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a),
    .rom_address(rom_addr_a), .rom_data(rom_data_a), .busy(busy_a));

  rom_access_arbiter #(.NUM_REQ(4), .ADDR_W(7), .DATA_W(8), .ROM_LATENCY(2)) u_b (
    .clock0(clock0), .global_resetn(global_resetn), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(ready_b), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
    .rom_address(rom_addr_b), .rom_data(rom_data_b), .busy(busy_b));

  rom_access_arbiter #(.NUM_REQ(4), .ADDR_W(7), .DATA_W(8), .ROM_LATENCY(3)) u_c (
    .clock0(clock0), .global_resetn(global_resetn), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(ready_c), .rsp_valid(rsp_valid_c), .rsp_data(rsp_data_c),
    .rom_address(rom_addr_c), .rom_data(rom_data_c), .busy(busy_c));

  always @(negedge clock0) begin
    if (mon_en) begin
      if (!$onehot0(rsp_valid_a) || !$onehot0(rsp_valid_b) || !$onehot0(rsp_valid_c) ||
          !$onehot0(ready_a) || !$onehot0(ready_b) || !$onehot0(ready_c))
        oh_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock0);
    #1;
  endtask

  task automatic set_addr(input int idx, input logic [6:0] a);
    req_addr[idx*AW +: AW] = a;
  endtask

  task automatic do_reset();
    global_resetn = 1'b0;
    req_valid     = '0;
    tick();
    tick();
    global_resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] t2a [4];
    int r;
    logic [6:0] ad;

    // reset state: requests present while reset is held must not be granted
    global_resetn = 1'b0;
    req_valid     = 4'hF;
    req_addr      = '0;
    tick();
    tick();
    #2;
    chk("rst_ready_a", 32'(ready_a), 32'h0);
    chk("rst_ready_c", 32'(ready_c), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid_a), 32'h0);
    chk("rst_rom_addr", 32'(rom_addr_a), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    mon_en = 1'b1;

    // single request on requester 2, latency 1
    global_resetn = 1'b1;
    req_valid = 4'b0100;
    set_addr(2, 7'h15);
    #2;
    chk("t1_ready", 32'(ready_a), 32'h4);
    chk("t1_busy_idle", 32'(busy_a), 32'h0);
    tick();
    req_valid = '0;
    set_addr(2, 7'h6B);
    #2;
    chk("t1_rom_addr", 32'(rom_addr_a), 32'h15);
    chk("t1_busy", 32'(busy_a), 32'h1);
    chk("t1_ready_wait", 32'(ready_a), 32'h0);
    chk("t1_rsp_early", 32'(rsp_valid_a), 32'h0);
    tick();
    #2;
    chk("t1_rsp_valid", 32'(rsp_valid_a), 32'h4);
    chk("t1_rsp_data", 32'(rsp_data_a), 32'(rom_fn(7'h15)));
    chk("t1_busy_done", 32'(busy_a), 32'h0);
    chk("t1_rom_addr_hold", 32'(rom_addr_a), 32'h15);
    tick();
    #2;
    chk("t1_rsp_pulse", 32'(rsp_valid_a), 32'h0);
    chk("t1_rsp_data_hold", 32'(rsp_data_a), 32'(rom_fn(7'h15)));

    // all four requesters held valid: grants rotate 0,1,2,3,0 every two cycles
    do_reset();
    t2a[0] = 7'h10; t2a[1] = 7'h21; t2a[2] = 7'h32; t2a[3] = 7'h43;
    for (int i = 0; i < 4; i++) set_addr(i, t2a[i]);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("t2_ready", 32'(ready_a), 32'(1 << (k % 4)));
      tick();
      #2;
      chk("t2_rom_addr", 32'(rom_addr_a), 32'(t2a[k % 4]));
      chk("t2_busy", 32'(busy_a), 32'h1);
      tick();
      #2;
      chk("t2_rsp_valid", 32'(rsp_valid_a), 32'(1 << (k % 4)));
      chk("t2_rsp_data", 32'(rsp_data_a), 32'(rom_fn(t2a[k % 4])));
    end
    req_valid = '0;
    tick();

    // latency 3: address 0x7F, then address 0x00 on the same requester
    do_reset();
    req_valid = 4'b0010;
    set_addr(1, 7'h7F);
    #2;
    chk("t3_ready", 32'(ready_c), 32'h2);
    tick();
    req_valid = '0;
    for (int i = 1; i <= 3; i++) begin
      #2;
      chk("t3_busy", 32'(busy_c), 32'h1);
      chk("t3_rsp_early", 32'(rsp_valid_c), 32'h0);
      tick();
    end
    #2;
    chk("t3_rsp_valid", 32'(rsp_valid_c), 32'h2);
    chk("t3_rsp_data", 32'(rsp_data_c), 32'(rom_fn(7'h7F)));
    chk("t3_busy_done", 32'(busy_c), 32'h0);
    set_addr(1, 7'h00);
    req_valid = 4'b0010;
    #2;
    chk("t3_ready2", 32'(ready_c), 32'h2);
    tick();
    req_valid = '0;
    repeat (3) tick();
    #2;
    chk("t3_rsp_valid2", 32'(rsp_valid_c), 32'h2);
    chk("t3_rsp_data2", 32'(rsp_data_c), 32'(rom_fn(7'h00)));

    // latency 2: reset mid-access drops it and restores requester-0-first priority
    do_reset();
    req_valid = 4'b0010;
    set_addr(1, 7'h55);
    #2;
    chk("t4_ready", 32'(ready_b), 32'h2);
    tick();
    req_valid = '0;
    global_resetn = 1'b0;
    #2;
    chk("t4_ready_rst", 32'(ready_b), 32'h0);
    tick();
    global_resetn = 1'b1;
    #2;
    chk("t4_rsp_dropped", 32'(rsp_valid_b), 32'h0);
    chk("t4_rom_addr", 32'(rom_addr_b), 32'h0);
    chk("t4_busy", 32'(busy_b), 32'h0);
    tick();
    #2;
    chk("t4_rsp_dropped2", 32'(rsp_valid_b), 32'h0);
    tick();
    set_addr(1, 7'h2A);
    set_addr(3, 7'h3C);
    req_valid = 4'b1010;
    #2;
    chk("t4_ready_after", 32'(ready_b), 32'h2);
    tick();
    req_valid = '0;
    tick();
    tick();
    #2;
    chk("t4_rsp_valid", 32'(rsp_valid_b), 32'h2);
    chk("t4_rsp_data", 32'(rsp_data_b), 32'(rom_fn(7'h2A)));

    // latency 2: requester 3 pulses only while busy and is never served
    do_reset();
    req_valid = 4'b0001;
    set_addr(0, 7'h01);
    #2;
    chk("t5_ready", 32'(ready_b), 32'h1);
    tick();
    req_valid = 4'b1000;
    set_addr(3, 7'h33);
    #2;
    chk("t5_ready_busy", 32'(ready_b), 32'h0);
    tick();
    req_valid = '0;
    #2;
    chk("t5_ready_busy2", 32'(ready_b), 32'h0);
    tick();
    #2;
    chk("t5_rsp_valid", 32'(rsp_valid_b), 32'h1);
    chk("t5_rsp_data", 32'(rsp_data_b), 32'(rom_fn(7'h01)));
    for (int i = 0; i < 3; i++) begin
      tick();
      #2;
      chk("t5_no_rsp3", 32'(rsp_valid_b), 32'h0);
      chk("t5_idle", 32'(busy_b), 32'h0);
    end

    // latency 1: random requesters and addresses, back-to-back
    do_reset();
    for (int n = 0; n < 256; n++) begin
      r  = int'($urandom_range(0, 3));
      ad = 7'($urandom_range(0, 127));
      set_addr(r, ad);
      req_valid = 4'(1 << r);
      #2;
      chk("rnd_ready", 32'(ready_a), 32'(1 << r));
      tick();
      req_valid = '0;
      set_addr(r, 7'($urandom));
      tick();
      #2;
      chk("rnd_rsp_valid", 32'(rsp_valid_a), 32'(1 << r));
      chk("rnd_rsp_data", 32'(rsp_data_a), 32'(rom_fn(ad)));
    end
    tick();

    chk("onehot", 32'(oh_bad), 32'h0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
